// File: rtl/legv8_pkg.sv
// ---------------------------------------------------------------------------
// legv8_pkg
// Shared constants and types for the LEGv8 front end.
// INSTR_W, OPCODE_W : instruction word width and opcode field width.
// OPCODE_MSB/LSB    : where the opcode sits in an instruction word. The
//                     control decoder consumes this field.
// INSTR_BYTES       : PC increment between sequential instructions.
// fetch_state_t     : the states of the instruction fetch FSM.
// ---------------------------------------------------------------------------
package legv8_pkg;

    localparam int INSTR_W     = 32;
    localparam int OPCODE_W    = 11;
    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 21;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        FLUSH,
        FAULT
    } fetch_state_t;

endpackage

// File: rtl/branch_target_adder.sv
// ---------------------------------------------------------------------------
// branch_target_adder
// Purely combinational branch target computation for the fetch unit.
// The result wraps modulo 2^ADDR_W.
// Ports:
//   pc_i         : PC of the branching instruction
//   offset_i     : sign-extended word offset
//   target_o     : pc_i + (offset_i << 2)
//   misaligned_o : target is not word aligned. Only pc_i[1:0] can cause this,
//                  because the shifted offset always has zero low bits.
// ---------------------------------------------------------------------------
module branch_target_adder #(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] offset_i,
    output logic [ADDR_W-1:0] target_o,
    output logic              misaligned_o
);

    assign target_o     = pc_i + (offset_i << 2);
    assign misaligned_o = |target_o[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Owns the program counter and fetches words from instruction memory over a
// req/ready handshake. It holds the fetched word in an output register that
// feeds the control decoder. It also handles branch redirect, downstream
// stall and fetch timeout.
// Ports:
//   clk, rst_n         : clock and asynchronous active-low reset
//   imem_req/addr      : fetch request and byte address (stable while req high)
//   imem_ready/rdata   : memory response; may come in the same cycle as req
//   branch_taken/pc/offset : single-cycle redirect from execute
//   stall              : downstream cannot take the current if_* contents
//   if_valid/pc/instr/opcode : held instruction and its opcode field
//   fetch_fault        : sticky timeout / misaligned-target fault
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import legv8_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_pc,
    input  logic [ADDR_W-1:0]   branch_offset,
    input  logic                stall,
    output logic                if_valid,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [OPCODE_W-1:0] if_opcode,
    output logic                fetch_fault
);

    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   flushAddr_q, flushAddr_d;
    logic [7:0]          wait_q, wait_d;
    logic                ifValid_q, ifValid_d;
    logic [ADDR_W-1:0]   ifPc_q, ifPc_d;
    logic [INSTR_W-1:0]  ifInstr_q, ifInstr_d;
    logic                fault_q, fault_d;

    logic [ADDR_W-1:0]   target;
    logic                misaligned;
    logic                outputFull;
    logic                reqActive;
    logic                waiting;
    logic [7:0]          waitInc;
    logic                timeout;
    logic                consume;

    branch_target_adder #(
        .ADDR_W (ADDR_W)
    ) u_target (
        .pc_i         (branch_pc),
        .offset_i     (branch_offset),
        .target_o     (target),
        .misaligned_o (misaligned)
    );

    // The output register is full when it holds a word that downstream will
    // not take. A new request is started only when a returning word could be
    // captured. This prevents an unconsumed word from being overwritten.
    assign outputFull = ifValid_q && stall;
    assign consume    = ifValid_q && !stall;
    assign reqActive  = ((state_q == FETCH) && !outputFull) || (state_q == FLUSH);
    assign waiting    = reqActive && !imem_ready;
    assign waitInc    = wait_q + 8'd1;
    assign timeout    = waiting && (waitInc == 8'(MAX_WAIT));

    // Next-state logic. A misaligned branch and a timeout both end in the
    // sticky FAULT state. A good branch redirects the PC and flushes the
    // output register. If a request is still outstanding, the FSM parks in
    // FLUSH so the memory sees a stable request until it answers.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flushAddr_d = flushAddr_q;
        wait_d      = wait_q;
        ifValid_d   = ifValid_q;
        ifPc_d      = ifPc_q;
        ifInstr_d   = ifInstr_q;
        fault_d     = fault_q;

        case (state_q)
            IDLE, FETCH, HOLD, FLUSH: begin
                wait_d = waiting ? waitInc : 8'd0;
                if (branch_taken && misaligned) begin
                    fault_d   = 1'b1;
                    state_d   = FAULT;
                    ifValid_d = 1'b0;
                    wait_d    = 8'd0;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                    wait_d  = 8'd0;
                end else if (branch_taken) begin
                    pc_d      = target;
                    ifValid_d = 1'b0;
                    if (waiting) begin
                        state_d     = FLUSH;
                        flushAddr_d = (state_q == FLUSH) ? flushAddr_q : pc_q;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    if (consume) begin
                        ifValid_d = 1'b0;
                    end
                    case (state_q)
                        IDLE: state_d = FETCH;
                        FETCH: begin
                            if (outputFull) begin
                                state_d = HOLD;
                            end else if (imem_ready) begin
                                ifInstr_d = imem_rdata;
                                ifPc_d    = pc_q;
                                ifValid_d = 1'b1;
                                pc_d      = pc_q + ADDR_W'(INSTR_BYTES);
                            end
                        end
                        HOLD: begin
                            if (!stall) begin
                                state_d = FETCH;
                            end
                        end
                        FLUSH: begin
                            if (imem_ready) begin
                                state_d = FETCH;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers. Reset is asynchronous, so every output
    // goes to zero as soon as rst_n falls, even in the middle of a request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            flushAddr_q <= '0;
            wait_q      <= 8'd0;
            ifValid_q   <= 1'b0;
            ifPc_q      <= '0;
            ifInstr_q   <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flushAddr_q <= flushAddr_d;
            wait_q      <= wait_d;
            ifValid_q   <= ifValid_d;
            ifPc_q      <= ifPc_d;
            ifInstr_q   <= ifInstr_d;
            fault_q     <= fault_d;
        end
    end

    // During FLUSH the memory still serves the stale request, so the address
    // it was given is presented instead of the already redirected PC.
    assign imem_req    = reqActive;
    assign imem_addr   = (state_q == FLUSH) ? flushAddr_q :
                         (state_q == FETCH) ? pc_q : '0;
    assign if_valid    = ifValid_q;
    assign if_pc       = ifPc_q;
    assign if_instr    = ifInstr_q;
    assign if_opcode   = ifInstr_q[OPCODE_MSB:OPCODE_LSB];
    assign fetch_fault = fault_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the LEGv8 control decoder.
- Owns the program counter and issues word fetches to instruction memory over a req/ready handshake.
- Holds each fetched instruction in an output register with a valid flag, exposing the opcode field instr[31:21] that drives the control decoder.
- Handles branch redirect, downstream stall and fetch timeout.

Parameters:
- ADDR_W, 64, width of PC and memory address.
- RESET_PC, 0, PC value loaded on reset.
- MAX_WAIT, 15, cycles a request may wait for imem_ready before a fault is raised (range 1..255).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held high until imem_ready.
- imem_addr  out  ADDR_W  byte address of the fetch; stable while imem_req high.
- imem_ready  in  1  imem_rdata valid this cycle; may arrive in the same cycle as imem_req (zero wait).
- imem_rdata  in  32  fetched instruction word.
- branch_taken  in  1  single-cycle redirect pulse (Branch AND Zero from execute).
- branch_pc  in  ADDR_W  PC of the branching instruction.
- branch_offset  in  ADDR_W  sign-extended word offset.
- stall  in  1  downstream cannot accept the current if_* contents.
- if_valid  out  1  if_pc, if_instr and if_opcode are valid.
- if_pc  out  ADDR_W  PC of the held instruction.
- if_instr  out  32  held instruction.
- if_opcode  out  11  if_instr[31:21], routed to the control decoder.
- fetch_fault  out  1  sticky timeout or misalignment fault.

Behaviour:
- Reset (asynchronous, any state, including mid-request): pc=RESET_PC, state=IDLE, wait counter=0. All outputs are 0: imem_req, imem_addr, if_valid, if_pc, if_instr, if_opcode, fetch_fault.
- States:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready, the instruction is captured when the output register is free (!if_valid or !stall); the output register is never overwritten while if_valid and stall.
  - HOLD: imem_req=0.
  - FLUSH: imem_req=1, imem_addr held at the stale address.
  - FAULT: imem_req=0; exited only by reset.
- FETCH transitions:
  - imem_ready and output free: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4; stay in FETCH.
  - Output full (if_valid and stall): no request is issued; go to HOLD.
- HOLD: return to FETCH the cycle after stall deasserts. if_valid drops on consumption unless a new capture occurs in the same cycle.
- Consumption: if_valid and !stall at a clock edge means the word is taken. if_valid goes to 0 unless replaced by a new capture on that edge.
- Zero-wait throughput: one instruction per cycle. Latency from reset release to first if_valid is 2 cycles.
- Branch redirect:
  - Target = branch_pc + (branch_offset<<2), computed modulo 2^ADDR_W.
  - On branch_taken: pc<=target and if_valid<=0 (flush).
  - If branch_taken arrives while imem_req is high and imem_ready is low, go to FLUSH. FLUSH keeps the request stable until imem_ready, discards that data, then goes to FETCH at the target.
  - If branch_taken and imem_ready coincide, the returning data is discarded and the next state is FETCH at the target.
- Priority: reset > branch_taken > stall > capture.
- Misaligned target (branch_pc[1:0]!=0): fetch_fault=1, go to FAULT.
- Timeout:
  - The 8-bit wait counter increments each cycle in FETCH/FLUSH while imem_req and !imem_ready.
  - It clears on imem_ready or on leaving those states.
  - When the counter reaches MAX_WAIT with imem_ready still low: fetch_fault=1, go to FAULT, imem_req=0.
  - if_valid keeps its value in FAULT.
- PC wrap: pc+4 wraps modulo 2^ADDR_W with no fault.

Decomposition:
- Shared package legv8_pkg:
  - INSTR_W=32, OPCODE_W=11, OPCODE_MSB=31, OPCODE_LSB=21, INSTR_BYTES=4.
  - fetch_state_t enum {IDLE, FETCH, HOLD, FLUSH, FAULT}.
- One sub-module: branch_target_adder, purely combinational. It computes branch_pc + (offset<<2) and flags misalignment.
- FSM, PC register and output register stay in instr_fetch_unit.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait memory -> imem_addr sequence 0x100, 0x104, 0x108. First if_valid 2 cycles after rst_n rises. if_opcode = rdata[31:21], e.g. 0xF8400000 -> if_opcode=0x7C2 (LDUR).
- Stall held 3 cycles while if_valid=1 -> if_instr/if_pc unchanged, imem_req=0 after entering HOLD. Release stall -> no instruction lost or duplicated.
- branch_taken with branch_pc=0x200, offset=-2 (all-ones..FE), while memory waits 4 cycles -> request at the stale address is held until ready and its data dropped. Next request address is 0x1F8; if_valid=0 meanwhile.
- branch_taken and imem_ready in the same cycle -> data discarded, next imem_addr=target, if_valid=0 next cycle.
- imem_ready never asserted, MAX_WAIT=15 -> fetch_fault=1 after 15 waiting cycles, imem_req=0, stays in FAULT. rst_n low mid-FAULT -> all outputs 0 immediately (asynchronous).
- Misaligned branch_pc=0x202 with branch_taken -> fetch_fault=1 next cycle. PC wrap: RESET_PC=2^64-4 -> second fetch address 0x0.
